// File: rtl/anti_theft_fsm.sv
// Anti-theft alarm controller: tracks doors and ignition, sequences the countdown timer,
// and drives the status LED (blinking while armed) and the siren enable.
module anti_theft_fsm #(
    parameter int BLINK_HALF_PERIOD = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       driver_door,
    input  logic       passenger_door,
    input  logic       reprogram,
    input  logic       expired,
    output logic       start_timer,
    output logic [1:0] interval,
    output logic       status,
    output logic       siren_enable,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        ARMED           = 3'd0,
        TRIGGERED       = 3'd1,
        SOUND_ALARM     = 3'd2,
        ALARM_HOLD      = 3'd3,
        DISARMED        = 3'd4,
        WAIT_DOOR_CLOSE = 3'd5,
        ARM_DELAY       = 3'd6
    } state_t;

    localparam logic [1:0] T_ARM_DELAY       = 2'b00;
    localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
    localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
    localparam logic [1:0] T_ALARM_ON        = 2'b11;

    localparam int            CW       = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_blink_cnt;
    logic          w_any_door;
    logic          w_blink_last;

    assign w_any_door   = driver_door | passenger_door;
    assign w_blink_last = (r_blink_cnt == CNT_LAST);
    assign state_out    = r_state;

    // Outputs are registered together with the state they belong to, so every
    // branch that changes state also sets the status/siren of the destination.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ARMED;
            r_blink_cnt  <= '0;
            start_timer  <= 1'b0;
            interval     <= T_ARM_DELAY;
            status       <= 1'b0;
            siren_enable <= 1'b0;
        end else begin
            start_timer <= 1'b0;
            if (reprogram) begin
                r_state      <= ARMED;
                r_blink_cnt  <= '0;
                status       <= 1'b0;
                siren_enable <= 1'b0;
            end else begin
                case (r_state)
                    ARMED: begin
                        if (driver_door) begin
                            r_state     <= TRIGGERED;
                            start_timer <= 1'b1;
                            interval    <= T_DRIVER_DELAY;
                            status      <= 1'b1;
                        end else if (passenger_door) begin
                            r_state     <= TRIGGERED;
                            start_timer <= 1'b1;
                            interval    <= T_PASSENGER_DELAY;
                            status      <= 1'b1;
                        end else if (w_blink_last) begin
                            r_blink_cnt <= '0;
                            status      <= ~status;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + CNT_ONE;
                        end
                    end
                    TRIGGERED: begin
                        if (ignition) begin
                            r_state <= DISARMED;
                            status  <= 1'b0;
                        end else if (expired) begin
                            r_state      <= SOUND_ALARM;
                            siren_enable <= 1'b1;
                        end
                    end
                    SOUND_ALARM: begin
                        if (ignition) begin
                            r_state      <= DISARMED;
                            status       <= 1'b0;
                            siren_enable <= 1'b0;
                        end else if (!w_any_door) begin
                            r_state     <= ALARM_HOLD;
                            start_timer <= 1'b1;
                            interval    <= T_ALARM_ON;
                        end
                    end
                    ALARM_HOLD: begin
                        if (ignition) begin
                            r_state      <= DISARMED;
                            status       <= 1'b0;
                            siren_enable <= 1'b0;
                        end else if (w_any_door) begin
                            r_state <= SOUND_ALARM;
                        end else if (expired) begin
                            r_state      <= ARMED;
                            r_blink_cnt  <= '0;
                            status       <= 1'b0;
                            siren_enable <= 1'b0;
                        end
                    end
                    DISARMED: begin
                        if (!ignition && driver_door) begin
                            r_state <= WAIT_DOOR_CLOSE;
                        end
                    end
                    WAIT_DOOR_CLOSE: begin
                        if (ignition) begin
                            r_state <= DISARMED;
                        end else if (!w_any_door) begin
                            r_state     <= ARM_DELAY;
                            start_timer <= 1'b1;
                            interval    <= T_ARM_DELAY;
                        end
                    end
                    ARM_DELAY: begin
                        if (ignition) begin
                            r_state <= DISARMED;
                        end else if (w_any_door) begin
                            r_state <= WAIT_DOOR_CLOSE;
                        end else if (expired) begin
                            r_state     <= ARMED;
                            r_blink_cnt <= '0;
                            status      <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ARMED;
                        r_blink_cnt  <= '0;
                        status       <= 1'b0;
                        siren_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Bench for anti_theft_fsm: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_anti_theft_fsm;

    localparam int H = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       ignition, driver_door, passenger_door, reprogram, expired;
    logic       start_timer;
    logic [1:0] interval;
    logic       status, siren_enable;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    anti_theft_fsm #(.BLINK_HALF_PERIOD(H)) dut (
        .clock          (clock),
        .reset          (reset),
        .ignition       (ignition),
        .driver_door    (driver_door),
        .passenger_door (passenger_door),
        .reprogram      (reprogram),
        .expired        (expired),
        .start_timer    (start_timer),
        .interval       (interval),
        .status         (status),
        .siren_enable   (siren_enable),
        .state_out      (state_out)
    );

    always #5 clock = ~clock;

    // Behavioural model: state number, cycles spent in ARMED since entry, last timer request.
    int         m_state;
    int         m_age;
    bit         m_start;
    logic [1:0] m_interval;
    bit         chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int next_state(input int s, input bit ign, input bit dd, input bit pd,
                                      input bit rp, input bit ex);
        bit door;
        door = dd | pd;
        if (rp) return 0;
        case (s)
            0:       return door ? 1 : 0;
            1:       return ign ? 4 : (ex ? 2 : 1);
            2:       return ign ? 4 : (door ? 2 : 3);
            3:       return ign ? 4 : (door ? 2 : (ex ? 0 : 3));
            4:       return (!ign && dd) ? 5 : 4;
            5:       return ign ? 4 : (door ? 5 : 6);
            6:       return ign ? 4 : (door ? 5 : (ex ? 0 : 6));
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state    = 0;
        m_age      = 0;
        m_start    = 1'b0;
        m_interval = 2'b00;
    endtask

    task automatic model_step(input bit ign, input bit dd, input bit pd, input bit rp, input bit ex);
        int n;
        n = next_state(m_state, ign, dd, pd, rp, ex);
        m_start = 1'b0;
        if (!rp) begin
            if (m_state == 0 && n == 1) begin
                m_start = 1'b1;
                m_interval = dd ? 2'b01 : 2'b10;
            end else if (m_state == 2 && n == 3) begin
                m_start = 1'b1;
                m_interval = 2'b11;
            end else if (m_state == 5 && n == 6) begin
                m_start = 1'b1;
                m_interval = 2'b00;
            end
        end
        if (n == 0) m_age = (rp || m_state != 0) ? 0 : m_age + 1;
        m_state = n;
    endtask

    function automatic bit m_status();
        if (m_state == 0) return ((m_age / H) % 2) == 1;
        return (m_state >= 1 && m_state <= 3);
    endfunction

    function automatic bit m_siren();
        return (m_state == 2 || m_state == 3);
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            check("state_out", state_out, m_state);
            check("start_timer", start_timer, m_start);
            check("interval", interval, m_interval);
            check("status", status, m_status());
            check("siren_enable", siren_enable, m_siren());
        end
    end

    task automatic drive(input bit ign, input bit dd, input bit pd, input bit rp, input bit ex);
        ignition       = ign;
        driver_door    = dd;
        passenger_door = pd;
        reprogram      = rp;
        expired        = ex;
        @(posedge clock);
        model_step(ign, dd, pd, rp, ex);
        #1;
    endtask

    bit exp_blink [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        reset = 1'b1;
        ignition = 0; driver_door = 0; passenger_door = 0; reprogram = 0; expired = 0;
        chk_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_state", state_out, 0);
        check("rst_start", start_timer, 0);
        check("rst_interval", interval, 0);
        check("rst_status", status, 0);
        check("rst_siren", siren_enable, 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Driver door trips the alarm; ignition disarms before expiry.
        drive(0, 1, 0, 0, 0);
        check("drv_start", start_timer, 1);
        check("drv_interval", interval, 2'b01);
        check("drv_state", state_out, 1);
        drive(0, 0, 0, 0, 0);
        check("drv_pulse_end", start_timer, 0);
        drive(1, 0, 0, 0, 0);
        check("disarm_state", state_out, 4);
        drive(0, 0, 0, 1, 0);
        check("reprog_armed", state_out, 0);

        // Passenger path into the siren and hold sequence.
        drive(0, 0, 1, 0, 0);
        check("pas_interval", interval, 2'b10);
        drive(0, 0, 1, 0, 1);
        check("sound_siren", siren_enable, 1);
        drive(0, 0, 0, 0, 0);
        check("hold_start", start_timer, 1);
        check("hold_interval", interval, 2'b11);
        drive(0, 1, 0, 0, 0);
        check("rehold_state", state_out, 2);
        check("rehold_nostart", start_timer, 0);
        check("rehold_siren", siren_enable, 1);
        drive(0, 0, 0, 0, 0);
        check("rehold_start", start_timer, 1);
        drive(0, 0, 0, 0, 1);
        check("hold_exp_state", state_out, 0);
        check("hold_exp_siren", siren_enable, 0);

        // Blink pattern with a 4-cycle half period.
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 0, 0, 0);
            check("blink", status, exp_blink[k]);
        end

        // Disarm, leave the car, re-arm sequence.
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check("wait_state", state_out, 5);
        drive(0, 0, 0, 0, 0);
        check("armdly_start", start_timer, 1);
        check("armdly_interval", interval, 2'b00);
        drive(0, 0, 1, 0, 0);
        check("armdly_door", state_out, 5);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        check("door_beats_exp", state_out, 5);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        check("armdly_exp", state_out, 0);

        // Asynchronous reset while the siren sounds.
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        check("pre_rst_siren", siren_enable, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_siren", siren_enable, 0);
        check("async_start", start_timer, 0);
        check("async_state", state_out, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reprogram out of TRIGGERED.
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        check("reprog_trig_state", state_out, 0);
        check("reprog_trig_start", start_timer, 0);

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                  ($urandom % 40) == 0, ($urandom % 3) == 0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
